arbitro_memoria_datos: RTL and testbench
========================================

Name: arbitro_memoria_datos

Overview:
Controller for the single-port data memory. It arbitrates between the MEM-stage CPU requester and the debug unit, sequences sub-word stores as a read-modify-write, and extends sub-word loads. The CPU sees a stall handshake. The debug unit sees a read-only, starvation-protected port.

Parameters:
NBITS, 32, data/address width
CELDAS, 16, memory depth in words; valid word index 0..CELDAS-1
DBG_MAX_WAIT, 8, cycles a pending debug request may be blocked by the CPU before it is forced through

Ports:
i_clk  in  1  clock, all state on posedge
i_reset  in  1  synchronous, active-high reset
i_CpuReq  in  1  CPU access request; held until o_CpuDone
i_CpuWe  in  1  1=store, 0=load
i_CpuSize  in  2  00 byte, 01 halfword, 11 word (10 = illegal)
i_CpuUnsigned  in  1  loads: 1 zero-extend, 0 sign-extend
i_CpuAddr  in  NBITS  byte address
i_CpuWData  in  NBITS  store data, right-aligned
o_CpuRData  out  NBITS  load result, valid with o_CpuDone
o_CpuDone  out  1  one-cycle completion pulse
o_CpuErr  out  1  qualifies o_CpuDone: misaligned/illegal/out of range
o_Stall  out  1  combinational: i_CpuReq & ~o_CpuDone
i_DbgReq  in  1  debug read request; held until o_DbgValid
i_DbgAddr  in  NBITS  debug word index
o_DbgRData  out  NBITS  debug read data
o_DbgValid  out  1  one-cycle pulse
o_MemAddr  out  NBITS  word index to memory
o_MemRead  out  1  memory read enable
o_MemWrite  out  1  memory write enable; the memory commits on the clock edge
o_MemWData  out  NBITS  write word
i_MemRData  in  NBITS  combinational read data

Behaviour:
- Reset: state IDLE. All outputs 0 except o_Stall, which follows its equation. Wait counter is 0. o_MemWrite is forced to 0 in any cycle where i_reset=1, so an aborted RMW never writes.
- States: IDLE, ACCESS, MERGE_WR, DBG_RD, RESP.
- Request fields (we, size, unsigned, addr, wdata) are latched on acceptance in IDLE. Inputs are ignored outside IDLE.
- Grant in IDLE:
  - Debug wins if i_DbgReq & (~i_CpuReq | wait==DBG_MAX_WAIT).
  - Otherwise the CPU wins if i_CpuReq.
- Wait counter: increments each cycle i_DbgReq=1 and debug is not granted. It saturates at DBG_MAX_WAIT and clears on debug grant.
- CPU error check at acceptance. Error if any of:
  - size=10;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr>>2 >= CELDAS.
  On error: IDLE->RESP, no memory access, o_CpuErr=1, o_CpuRData=0.
- Word store: IDLE(T) -> ACCESS(T+1), which asserts o_MemWrite with o_MemWData=wdata -> RESP(T+2), o_CpuDone=1.
- Load: ACCESS(T+1) asserts o_MemRead. The lane is selected by addr[1:0], then extended and registered -> RESP(T+2) with o_CpuDone and o_CpuRData.
- Sub-word store: ACCESS(T+1) reads and registers the word with the new lane merged in. MERGE_WR(T+2) writes the merged word. RESP(T+3) asserts o_CpuDone.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], half h = bits [16h+15:16h].
- Debug: IDLE(T) -> DBG_RD(T+1), read of word i_DbgAddr -> IDLE(T+2) with o_DbgValid and o_DbgRData registered.
  - Debug index >= CELDAS: no read, o_DbgRData=0, still valid.
- RESP always returns to IDLE; no acceptance happens in RESP. Requesters update req on the edge ending their done/valid cycle.
- o_MemAddr = latched word index in ACCESS/MERGE_WR/DBG_RD, else 0. o_MemRead/o_MemWrite are 0 in IDLE/RESP.
- o_CpuDone, o_CpuErr and o_DbgValid are single-cycle pulses. o_CpuRData holds until the next CPU completion.

Test Plan:
- Word store 0xDEADBEEF @0x8, then word load @0x8 -> o_MemWrite in T+1 with index 2; load completes with o_CpuDone at T+2, data 0xDEADBEEF.
- Word 0x11223344 @0x4; SB 0xAA @0x6 -> RMW: read T+1, write 0x11AA3344 T+2, done T+3. LB @0x6 signed -> 0xFFFFFFAA; LBU -> 0x000000AA.
- LH @0x5 -> done+err at T+1, no o_MemRead/o_MemWrite. Word load @0x40 (CELDAS=16) -> err.
- CPU requests back-to-back continuously with debug pending -> debug granted after exactly DBG_MAX_WAIT=8 blocked cycles; CPU stalls during DBG_RD; counter returns to 0.
- i_DbgReq and i_CpuReq rise together, counter 0 -> CPU first; debug served on the next IDLE; o_DbgValid carries correct word.
- Reset asserted during MERGE_WR -> no write that cycle, memory unchanged, state IDLE, all pulses 0.

Source files
------------

// File: rtl/arbitro_memoria_datos.sv
// Data-memory controller: arbitrates CPU vs. debug access to a single-port memory,
// runs sub-word stores as read-modify-write and extends sub-word loads.
module arbitro_memoria_datos #(
    parameter int NBITS        = 32,
    parameter int CELDAS       = 16,
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_CpuReq,
    input  logic             i_CpuWe,
    input  logic [1:0]       i_CpuSize,
    input  logic             i_CpuUnsigned,
    input  logic [NBITS-1:0] i_CpuAddr,
    input  logic [NBITS-1:0] i_CpuWData,
    output logic [NBITS-1:0] o_CpuRData,
    output logic             o_CpuDone,
    output logic             o_CpuErr,
    output logic             o_Stall,
    input  logic             i_DbgReq,
    input  logic [NBITS-1:0] i_DbgAddr,
    output logic [NBITS-1:0] o_DbgRData,
    output logic             o_DbgValid,
    output logic [NBITS-1:0] o_MemAddr,
    output logic             o_MemRead,
    output logic             o_MemWrite,
    output logic [NBITS-1:0] o_MemWData,
    input  logic [NBITS-1:0] i_MemRData
);

    localparam int WW = $clog2(DBG_MAX_WAIT + 1);

    typedef enum logic [2:0] {IDLE, ACCESS, MERGE_WR, DBG_RD, RESP} state_t;

    state_t           state, state_d;
    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [NBITS-1:0] addr_q;
    logic [NBITS-1:0] wdata_q;
    logic             err_q;
    logic [NBITS-1:0] dbg_idx_q;
    logic [NBITS-1:0] merged_q;
    logic [NBITS-1:0] cpu_rdata_q;
    logic [NBITS-1:0] dbg_rdata_q;
    logic             dbg_valid_q;
    logic [WW-1:0]    wait_q;

    logic             dbg_pending, dbg_grant, cpu_grant, req_err, dbg_in_range;
    logic [NBITS-1:0] word_idx;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [NBITS-1:0] load_val, merged;
    logic             mem_write;

    // A debug request is still held high during DBG_RD and its valid cycle; it is
    // not pending then, so it neither re-grants nor ages the wait counter.
    assign dbg_pending  = i_DbgReq & ~dbg_valid_q & (state != DBG_RD);
    assign dbg_grant    = (state == IDLE) & dbg_pending &
                          (~i_CpuReq | (wait_q == WW'(DBG_MAX_WAIT)));
    assign cpu_grant    = (state == IDLE) & ~dbg_grant & i_CpuReq;
    assign dbg_in_range = dbg_idx_q < NBITS'(CELDAS);
    assign word_idx     = i_CpuAddr >> 2;

    assign req_err = (i_CpuSize == 2'b10) |
                     ((i_CpuSize == 2'b01) & i_CpuAddr[0]) |
                     ((i_CpuSize == 2'b11) & (i_CpuAddr[1:0] != 2'b00)) |
                     (word_idx >= NBITS'(CELDAS));

    assign lane_b = i_MemRData[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = i_MemRData[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every combinationally written signal gets a default first so no latch is inferred.
        load_val = i_MemRData;
        merged   = i_MemRData;
        case (size_q)
            2'b00: begin
                load_val = {{(NBITS-8){~uns_q & lane_b[7]}}, lane_b};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = {{(NBITS-16){~uns_q & lane_h[15]}}, lane_h};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state;
        o_MemAddr   = '0;
        o_MemRead   = 1'b0;
        mem_write   = 1'b0;
        o_MemWData  = '0;
        case (state)
            IDLE: begin
                if (dbg_grant)      state_d = DBG_RD;
                else if (cpu_grant) state_d = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                o_MemAddr = addr_q >> 2;
                if (we_q && size_q == 2'b11) begin
                    mem_write  = 1'b1;
                    o_MemWData = wdata_q;
                    state_d    = RESP;
                end else begin
                    o_MemRead = 1'b1;
                    state_d   = we_q ? MERGE_WR : RESP;
                end
            end
            MERGE_WR: begin
                o_MemAddr  = addr_q >> 2;
                mem_write  = 1'b1;
                o_MemWData = merged_q;
                state_d    = RESP;
            end
            DBG_RD: begin
                o_MemAddr = dbg_idx_q;
                o_MemRead = dbg_in_range;
                state_d   = IDLE;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The memory commits on the edge, so an RMW cut short by reset must not write.
    assign o_MemWrite = mem_write & ~i_reset;

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            dbg_idx_q   <= '0;
            merged_q    <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            dbg_valid_q <= 1'b0;
            wait_q      <= '0;
        end else begin
            state       <= state_d;
            dbg_valid_q <= (state == DBG_RD);

            if (cpu_grant) begin
                we_q    <= i_CpuWe;
                size_q  <= i_CpuSize;
                uns_q   <= i_CpuUnsigned;
                addr_q  <= i_CpuAddr;
                wdata_q <= i_CpuWData;
                err_q   <= req_err;
                if (req_err) cpu_rdata_q <= '0;
            end

            if (dbg_grant) dbg_idx_q <= i_DbgAddr;

            if (dbg_grant)
                wait_q <= '0;
            else if (dbg_pending && wait_q != WW'(DBG_MAX_WAIT))
                wait_q <= wait_q + 1'b1;

            if (state == ACCESS) begin
                if (we_q) merged_q    <= merged;
                else      cpu_rdata_q <= load_val;
            end

            if (state == DBG_RD) dbg_rdata_q <= dbg_in_range ? i_MemRData : '0;
        end
    end

    assign o_CpuDone  = (state == RESP);
    assign o_CpuErr   = (state == RESP) & err_q;
    assign o_CpuRData = cpu_rdata_q;
    assign o_Stall    = i_CpuReq & ~o_CpuDone;
    assign o_DbgRData = dbg_rdata_q;
    assign o_DbgValid = dbg_valid_q;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Directed bench for arbitro_memoria_datos with a small behavioural memory attached.
module tb_arbitro_memoria_datos;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_uns;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_err, stall;
    logic        dbg_req, dbg_valid;
    logic [31:0] dbg_addr, dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem [16];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    arbitro_memoria_datos #(.NBITS(32), .CELDAS(16), .DBG_MAX_WAIT(8)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_CpuReq(cpu_req), .i_CpuWe(cpu_we), .i_CpuSize(cpu_size),
        .i_CpuUnsigned(cpu_uns), .i_CpuAddr(cpu_addr), .i_CpuWData(cpu_wdata),
        .o_CpuRData(cpu_rdata), .o_CpuDone(cpu_done), .o_CpuErr(cpu_err), .o_Stall(stall),
        .i_DbgReq(dbg_req), .i_DbgAddr(dbg_addr), .o_DbgRData(dbg_rdata), .o_DbgValid(dbg_valid),
        .o_MemAddr(mem_addr), .o_MemRead(mem_read), .o_MemWrite(mem_write),
        .o_MemWData(mem_wdata), .i_MemRData(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one CPU access; cycle numbers are relative to the IDLE cycle of acceptance.
    task automatic cpu_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int done_n, output logic err, output logic [31:0] rdata,
                          output int rd_n, output int wr_n,
                          output logic [31:0] wr_addr, output logic [31:0] wr_data);
        done_n = -1; rd_n = -1; wr_n = -1; err = 1'b0; rdata = '0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        cpu_we = we; cpu_size = size; cpu_uns = uns; cpu_addr = addr; cpu_wdata = wdata;
        cpu_req = 1'b1;
        for (int n = 1; n <= 8 && done_n < 0; n++) begin
            @(negedge clk);
            if (mem_read && rd_n < 0) rd_n = n;
            if (mem_write && wr_n < 0) begin
                wr_n = n; wr_addr = mem_addr; wr_data = mem_wdata;
            end
            if (cpu_done) begin
                done_n = n; err = cpu_err; rdata = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic dbg_op(input logic [31:0] idx, output int valid_n,
                          output logic [31:0] data, output int rd_n);
        valid_n = -1; rd_n = -1; data = '0;
        @(negedge clk);
        dbg_addr = idx; dbg_req = 1'b1;
        for (int n = 1; n <= 8 && valid_n < 0; n++) begin
            @(negedge clk);
            if (mem_read && rd_n < 0) rd_n = n;
            if (dbg_valid) begin
                valid_n = n; data = dbg_rdata;
            end
        end
        dbg_req = 1'b0;
    endtask

    int          d_n, r_n, w_n, v_n, dones;
    logic        e;
    logic [31:0] rd, wa, wd, dd;
    logic        s_stall, s_rd;
    logic [31:0] s_addr;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b11; cpu_uns = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; dbg_req = 1'b0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_done", cpu_done, 0);
        check("rst_err", cpu_err, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_dbg_valid", dbg_valid, 0);
        check("rst_mem_ctl", {mem_read, mem_write}, 0);
        check("rst_mem_addr", mem_addr, 0);
        cpu_req = 1'b1; #1;
        check("rst_stall_eq", stall, 1);
        cpu_req = 1'b0; #1;
        check("rst_stall_low", stall, 0);
        @(negedge clk); rst = 1'b0;

        cpu_op(1, 2'b11, 0, 32'h8, 32'hDEADBEEF, d_n, e, rd, r_n, w_n, wa, wd);
        check("sw_done_cycle", d_n, 2);
        check("sw_write_cycle", w_n, 1);
        check("sw_write_idx", wa, 2);
        check("sw_write_data", wd, 32'hDEADBEEF);
        check("sw_no_read", r_n, -1);
        check("sw_err", e, 0);

        cpu_op(0, 2'b11, 0, 32'h8, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lw_done_cycle", d_n, 2);
        check("lw_read_cycle", r_n, 1);
        check("lw_data", rd, 32'hDEADBEEF);

        cpu_op(1, 2'b11, 0, 32'h4, 32'h11223344, d_n, e, rd, r_n, w_n, wa, wd);
        check("sw4_done_cycle", d_n, 2);

        cpu_op(1, 2'b00, 0, 32'h6, 32'h000000AA, d_n, e, rd, r_n, w_n, wa, wd);
        check("sb_read_cycle", r_n, 1);
        check("sb_write_cycle", w_n, 2);
        check("sb_write_idx", wa, 1);
        check("sb_merged", wd, 32'h11AA3344);
        check("sb_done_cycle", d_n, 3);

        cpu_op(0, 2'b00, 0, 32'h6, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lb_signed", rd, 32'hFFFFFFAA);
        cpu_op(0, 2'b00, 1, 32'h6, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lbu", rd, 32'h000000AA);
        cpu_op(0, 2'b01, 0, 32'h4, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lh_low", rd, 32'h00003344);
        cpu_op(0, 2'b01, 0, 32'h6, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lh_high", rd, 32'h000011AA);

        cpu_op(1, 2'b01, 0, 32'h2, 32'hCAFE8001, d_n, e, rd, r_n, w_n, wa, wd);
        check("sh_merged", wd, 32'h80010000);
        cpu_op(0, 2'b01, 0, 32'h2, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lh_neg", rd, 32'hFFFF8001);
        cpu_op(0, 2'b01, 1, 32'h2, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lhu", rd, 32'h00008001);

        cpu_op(0, 2'b01, 0, 32'h5, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lh_mis_done", d_n, 1);
        check("lh_mis_err", e, 1);
        check("lh_mis_rdata", rd, 0);
        check("lh_mis_no_mem", {r_n, w_n} == {-32'sd1, -32'sd1}, 1);
        cpu_op(0, 2'b11, 0, 32'h40, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lw_range_err", e, 1);
        check("lw_range_no_read", r_n, -1);
        cpu_op(0, 2'b10, 0, 32'h8, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("size10_err", e, 1);
        cpu_op(1, 2'b11, 0, 32'h9, 32'h12345678, d_n, e, rd, r_n, w_n, wa, wd);
        check("sw_mis_err", e, 1);
        check("sw_mis_no_write", w_n, -1);
        check("sw_mis_mem", mem[2], 32'hDEADBEEF);
        cpu_op(0, 2'b11, 0, 32'h3C, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("lw_last_ok", e, 0);

        dbg_op(1, v_n, dd, r_n);
        check("dbg_valid_cycle", v_n, 2);
        check("dbg_data", dd, 32'h11AA3344);
        dbg_op(20, v_n, dd, r_n);
        check("dbg_oor_valid", v_n, 2);
        check("dbg_oor_data", dd, 0);
        check("dbg_oor_no_read", r_n, -1);

        // Starvation: CPU loads back-to-back, debug raised during an ACCESS cycle.
        @(negedge clk);
        cpu_we = 0; cpu_size = 2'b11; cpu_uns = 0; cpu_addr = 32'h8; cpu_req = 1'b1;
        @(negedge clk);
        check("starve_access", mem_read, 1);
        dbg_addr = 1; dbg_req = 1'b1;
        v_n = -1; dones = 0; s_stall = 0; s_rd = 0; s_addr = '0; dd = '0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (cpu_done) dones++;
            if (n == 9) begin
                s_stall = stall; s_rd = mem_read; s_addr = mem_addr;
            end
            if (dbg_valid && v_n < 0) begin
                v_n = n; dd = dbg_rdata; dbg_req = 1'b0;
            end
        end
        for (int k = 0; k < 6 && cpu_req; k++) begin
            @(negedge clk);
            if (cpu_done) cpu_req = 1'b0;
        end
        check("starve_drain", cpu_req, 0);
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("starve_valid_cycle", v_n, 10);
        check("starve_dbg_data", dd, 32'h11AA3344);
        check("starve_stall_dbgrd", s_stall, 1);
        check("starve_dbgrd_read", {s_rd, s_addr}, {1'b1, 32'd1});
        check("starve_cpu_dones", dones, 4);
        check("starve_cpu_data", cpu_rdata, 32'hDEADBEEF);

        // Simultaneous requests with the wait counter cleared: CPU goes first.
        @(negedge clk);
        cpu_addr = 32'h8; cpu_req = 1'b1; dbg_addr = 2; dbg_req = 1'b1;
        d_n = -1; v_n = -1; dd = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (cpu_done && d_n < 0) begin d_n = n; cpu_req = 1'b0; end
            if (dbg_valid && v_n < 0) begin v_n = n; dd = dbg_rdata; dbg_req = 1'b0; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("simul_cpu_done", d_n, 2);
        check("simul_dbg_valid", v_n, 5);
        check("simul_dbg_data", dd, 32'hDEADBEEF);

        // Reset landing in MERGE_WR of a byte store must suppress the write.
        @(negedge clk);
        cpu_we = 1; cpu_size = 2'b00; cpu_addr = 32'h1; cpu_wdata = 32'h55; cpu_req = 1'b1;
        @(negedge clk);
        check("rmw_rst_read", mem_read, 1);
        @(negedge clk);
        check("rmw_rst_pre_write", mem_write, 1);
        check("rmw_rst_pre_data", mem_wdata, 32'h80015500);
        rst = 1'b1; cpu_req = 1'b0; #1;
        check("rmw_rst_write_gated", mem_write, 0);
        @(negedge clk);
        check("rmw_rst_pulses", {cpu_done, cpu_err, dbg_valid}, 0);
        check("rmw_rst_mem", mem[0], 32'h80010000);
        check("rmw_rst_rdata", cpu_rdata, 0);
        rst = 1'b0;
        cpu_op(0, 2'b11, 0, 32'h0, 0, d_n, e, rd, r_n, w_n, wa, wd);
        check("post_rst_done", d_n, 2);
        check("post_rst_data", rd, 32'h80010000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
